spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- SPI bus master: the initiating end of the 4-wire link that our SPI slave answers.
- Generates ss/sclk/mosi from the system clock and shifts 8-bit bytes out on mosi while capturing miso.
- Sits between a byte-wide local interface (write/ack, done/data) and the off-chip or inter-FPGA SPI pins.
- Mode 0 only: sclk idles low; mosi changes on falling edges (first bit before first rising edge); miso is sampled on rising edges.
- MSB first by default; multi-byte bursts keep ss asserted.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period. Legal values ≥2. Use ≥4 when driving a slave that oversamples sclk with a 3-flop synchroniser.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_i  in  8  byte to transmit; sampled when accepted
- wr_en_i  in  1  write request; level, held until we_ack_o
- we_ack_o  out  1  one-cycle pulse: data_i accepted this cycle
- data_o  out  8  last received byte; stable until next done_o
- done_o  out  1  one-cycle pulse: byte complete, data_o updated
- busy_o  out  1  high whenever state ≠ IDLE
- ss_o  out  1  slave select, active low
- sclk_o  out  1  serial clock
- mosi_o  out  1  master-out serial data
- miso_i  in  1  master-in serial data; asynchronous, registered once before use

Behaviour:
- Reset, asynchronous, any state: state=IDLE, ss_o=1, sclk_o=0, mosi_o=1, data_o=0, we_ack_o=0, done_o=0, busy_o=0. Divider and bit counters are cleared.
- Reset mid-byte aborts the byte with no done_o. ss_o rises immediately.
- Divider: counts 0..CLK_DIV-1 and wraps. It runs only outside IDLE and restarts at 0 on every state entry. "tick" = divider at CLK_DIV-1.
- IDLE, wr_en_i=1: next cycle ss_o=0, mosi_o=data_i[7], tx shift reg=data_i, we_ack_o=1 for that cycle, bit count=0, go to SETUP. busy_o also rises that cycle.
- SETUP, tick: sclk_o←1 (rising edge 1), go to SHIFT.
- SHIFT, each tick toggles sclk_o.
  - Rising edge: rx shift reg ← {rx[6:0], miso_q}; bit count +1.
  - Falling edge with bit count <8: mosi_o ← next tx bit.
  - Falling edge with bit count =8: data_o ← rx, done_o pulses.
    - If wr_en_i=1 in that same cycle (burst): accept the new byte (we_ack_o pulse, mosi_o←data_i[7], count←0) and stay in SHIFT. The next rising edge comes CLK_DIV later, so there is no ss gap.
    - Otherwise mosi_o←1 and go to HOLD.
- HOLD, tick: ss_o←1, go to GAP.
- GAP, tick: go to IDLE.
- wr_en_i outside IDLE and outside the byte-boundary cycle is not acknowledged. The request stays pending; the initiator must keep it asserted.
- Timing, single byte, T = cycle ss_o falls:
  - rising edges at T+CLK_DIV·(2k+1), k=0..7
  - last falling edge and done_o at T+16·CLK_DIV
  - ss_o high at T+17·CLK_DIV
  - busy_o low at T+18·CLK_DIV
- Minimum ss-high time between frames: CLK_DIV+1 cycles.
- Outputs ss_o, sclk_o, mosi_o come straight from flops; they are glitch-free.

Optional Feature:
- SPI_MASTER_LSB_FIRST_EN
  - Defined: transmit data_i[0] first; rx shifts right ({miso_q, rx[7:1]}), so the first received bit lands in data_o[0].
  - Undefined: MSB first as above.
  - Timing, handshake and state machine are identical either way.

Test Plan:
- CLK_DIV=4, mosi looped to miso, wr_en_i with 8'hA5 → we_ack_o one pulse; 8 sclk rising edges at T+4,12,…,60; done_o at T+64 with data_o=8'hA5; ss_o high at T+68; busy_o low at T+72.
- miso tied 0, send 8'hFF → data_o=8'h00; mosi_o reads 1,1,1,1,1,1,1,1 on every rising edge; mosi_o=1 after frame.
- Burst: wr_en_i held with 8'h3C, then 8'hC3 presented before the first done_o → two we_ack_o pulses; ss_o low continuously; 16 rising edges; loopback gives data_o 8'h3C then 8'hC3.
- wr_en_i raised mid-byte at T+20 with 8'h55, then dropped before the byte boundary → no we_ack_o; frame ends normally; no second frame starts.
- rst_n pulsed low at T+30 mid-byte → same cycle ss_o=1, sclk_o=0, mosi_o=1, busy_o=0; no done_o; a new write after release yields a full, correct frame.
- Build with SPI_MASTER_LSB_FIRST_EN, send 8'h01 in loopback → mosi_o=1 on the first rising edge then 0s; data_o=8'h01.

Source files
------------

// File: rtl/spi_master_if.sv
// ============================================================================
//  Module   : spi_master_if
//  Purpose  : Byte-wide local request/response bundle of the SPI master.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface spi_master_if;
    logic [7:0] data_i;
    logic       wr_en_i;
    logic       we_ack_o;
    logic [7:0] data_o;
    logic       done_o;
    logic       busy_o;

    // Initiator side: issues bytes, observes completion
    modport master (
        output data_i, wr_en_i,
        input  we_ack_o, data_o, done_o, busy_o
    );

    // SPI master side: serves the initiator
    modport slave (
        input  data_i, wr_en_i,
        output we_ack_o, data_o, done_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
//  Module   : spi_master
//  Purpose  : Mode-0 SPI master, 8-bit frames, back-to-back burst support.
//             Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    spi_master_if.slave bus,
    output logic        ss_o,
    output logic        sclk_o,
    output logic        mosi_o,
    input  wire logic   miso_i
);

    localparam int             DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [6:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       data_q, data_d;
    logic             ss_q, ss_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             miso_q;

    logic             w_tick;
    logic             w_first_bit;
    logic [6:0]       w_tx_load;
    logic [6:0]       w_tx_shift;
    logic             w_next_bit;
    logic [7:0]       w_rx_shift;

    // The first bit goes straight to mosi; only the remaining seven are held
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign w_first_bit = bus.data_i[0];
    assign w_tx_load   = bus.data_i[7:1];
    assign w_next_bit  = tx_q[0];
    assign w_tx_shift  = {1'b0, tx_q[6:1]};
    assign w_rx_shift  = {miso_q, rx_q[7:1]};
`else
    assign w_first_bit = bus.data_i[7];
    assign w_tx_load   = bus.data_i[6:0];
    assign w_next_bit  = tx_q[6];
    assign w_tx_shift  = {tx_q[5:0], 1'b0};
    assign w_rx_shift  = {rx_q[6:0], miso_q};
`endif

    assign w_tick = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || w_tick) ? '0 : div_q + 1'b1;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.wr_en_i) begin
                    ss_d    = 1'b0;
                    mosi_d  = w_first_bit;
                    tx_d    = w_tx_load;
                    ack_d   = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    sclk_d  = 1'b1;
                    rx_d    = w_rx_shift;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d  = w_rx_shift;
                        cnt_d = cnt_q + 4'd1;
                    end else if (cnt_q != 4'd8) begin
                        tx_d   = w_tx_shift;
                        mosi_d = w_next_bit;
                    end else begin
                        data_d = rx_q;
                        done_d = 1'b1;
                        // Byte boundary: a pending request continues the burst
                        if (bus.wr_en_i) begin
                            ack_d  = 1'b1;
                            mosi_d = w_first_bit;
                            tx_d   = w_tx_load;
                            cnt_d  = 4'd0;
                        end else begin
                            mosi_d  = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    ss_d    = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (w_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= 4'd0;
            tx_q    <= 7'd0;
            rx_q    <= 8'd0;
            data_q  <= 8'd0;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            miso_q  <= miso_i;
        end
    end

    assign ss_o         = ss_q;
    assign sclk_o       = sclk_q;
    assign mosi_o       = mosi_q;
    assign bus.we_ack_o = ack_q;
    assign bus.done_o   = done_q;
    assign bus.data_o   = data_q;
    assign bus.busy_o   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
//  Module   : tb_spi_master
//  Purpose  : Self-checking bench for spi_master (CLK_DIV = 4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_master;

    localparam int CLK_DIV = 4;

    logic clk;
    logic rst_n;
    logic ss_o, sclk_o, mosi_o;
    logic miso_i;
    logic loop_en;
    logic miso_fix;

    spi_master_if bus ();

    spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .ss_o   (ss_o),
        .sclk_o (sclk_o),
        .mosi_o (mosi_o),
        .miso_i (miso_i)
    );

    assign miso_i = loop_en ? mosi_o : miso_fix;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Scoreboard and frame observation
    logic [7:0] sb[$];
    int         cyc = 0;
    int         t0 = 0;
    int         rise_n, ack_n, done_n;
    int         rise_t[32];
    int         done_t, ss_hi_t, busy_lo_t;
    logic [15:0] mosi_seq;
    logic       prev_sclk = 1'b0, prev_ss = 1'b1, prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!ss_o && prev_ss) begin
            t0 = cyc; rise_n = 0; ack_n = 0; done_n = 0;
            done_t = -1; ss_hi_t = -1; busy_lo_t = -1; mosi_seq = '0;
        end
        if (sclk_o && !prev_sclk) begin
            if (rise_n < 32) rise_t[rise_n] = cyc - t0;
            mosi_seq = {mosi_seq[14:0], mosi_o};
            rise_n++;
        end
        if (bus.we_ack_o) ack_n++;
        if (bus.done_o) begin
            done_t = cyc - t0;
            done_n++;
            if (sb.size() == 0) check_eq("unexpected_done", 32'd1, 32'd0);
            else check_eq("data_o", {24'd0, bus.data_o}, {24'd0, sb.pop_front()});
        end
        if (ss_o && !prev_ss) ss_hi_t = cyc - t0;
        if (!bus.busy_o && prev_busy) busy_lo_t = cyc - t0;
        prev_sclk = sclk_o; prev_ss = ss_o; prev_busy = bus.busy_o;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (bus.we_ack_o) break;
        end
        if (k == 100) check_eq({tag, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit expect_done);
        bus.data_i  = b;
        bus.wr_en_i = 1'b1;
        if (expect_done) sb.push_back(b);
    endtask

    function automatic logic [7:0] wire_order(input logic [7:0] b);
`ifdef SPI_MASTER_LSB_FIRST_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
`else
        return b;
`endif
    endfunction

    initial begin
        rst_n = 1'b0; loop_en = 1'b1; miso_fix = 1'b0;
        bus.data_i = 8'h00; bus.wr_en_i = 1'b0;
        wait_cycles(3);
        check_eq("rst_ss", ss_o, 1'b1);
        check_eq("rst_sclk", sclk_o, 1'b0);
        check_eq("rst_mosi", mosi_o, 1'b1);
        check_eq("rst_data", bus.data_o, 8'h00);
        check_eq("rst_busy", bus.busy_o, 1'b0);
        check_eq("rst_ack_done", {bus.we_ack_o, bus.done_o}, 2'b00);
        rst_n = 1'b1;
        wait_cycles(2);

        // Loopback single byte with full timing
        write_byte(8'hA5, 1);
        wait_ack("t1");
        bus.wr_en_i = 1'b0;
        check_eq("t1_ss_low_at_ack", ss_o, 1'b0);
        check_eq("t1_busy_at_ack", bus.busy_o, 1'b1);
        wait_cycles(80);
        check_eq("t1_rises", rise_n, 8);
        check_eq("t1_rise0", rise_t[0], 4);
        check_eq("t1_rise1", rise_t[1], 12);
        check_eq("t1_rise7", rise_t[7], 60);
        check_eq("t1_done_t", done_t, 64);
        check_eq("t1_ss_hi_t", ss_hi_t, 68);
        check_eq("t1_busy_lo_t", busy_lo_t, 72);
        check_eq("t1_acks", ack_n, 1);
        check_eq("t1_mosi_seq", mosi_seq[7:0], wire_order(8'hA5));

        // miso tied low, all-ones byte
        loop_en = 1'b0;
        write_byte(8'hFF, 0);
        sb.push_back(8'h00);
        wait_ack("t2");
        bus.wr_en_i = 1'b0;
        wait_cycles(80);
        check_eq("t2_mosi_seq", mosi_seq[7:0], 8'hFF);
        check_eq("t2_mosi_idle", mosi_o, 1'b1);
        check_eq("t2_done_n", done_n, 1);
        loop_en = 1'b1;

        // Two-byte burst
        write_byte(8'h3C, 1);
        wait_ack("t3a");
        write_byte(8'hC3, 1);
        wait_ack("t3b");
        bus.wr_en_i = 1'b0;
        wait_cycles(90);
        check_eq("t3_rises", rise_n, 16);
        check_eq("t3_acks", ack_n, 2);
        check_eq("t3_done_n", done_n, 2);
        check_eq("t3_done_t", done_t, 128);
        check_eq("t3_ss_hi_t", ss_hi_t, 132);
        check_eq("t3_mosi_seq", mosi_seq, {wire_order(8'h3C), wire_order(8'hC3)});

        // Request raised mid-byte and withdrawn before the boundary
        write_byte(8'h5A, 1);
        wait_ack("t4");
        bus.wr_en_i = 1'b0;
        wait_cycles(19);
        write_byte(8'h55, 0);
        wait_cycles(30);
        bus.wr_en_i = 1'b0;
        wait_cycles(60);
        check_eq("t4_acks", ack_n, 1);
        check_eq("t4_done_n", done_n, 1);
        check_eq("t4_rises", rise_n, 8);
        check_eq("t4_idle", {ss_o, bus.busy_o}, 2'b10);

        // Reset mid-byte
        write_byte(8'h96, 0);
        wait_ack("t5");
        bus.wr_en_i = 1'b0;
        wait_cycles(29);
        rst_n = 1'b0;
        #1;
        check_eq("t5_ss", ss_o, 1'b1);
        check_eq("t5_sclk", sclk_o, 1'b0);
        check_eq("t5_mosi", mosi_o, 1'b1);
        check_eq("t5_busy", bus.busy_o, 1'b0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        check_eq("t5_no_done", done_n, 0);
        write_byte(8'h69, 1);
        wait_ack("t5b");
        bus.wr_en_i = 1'b0;
        wait_cycles(80);
        check_eq("t5b_rises", rise_n, 8);
        check_eq("t5b_done_n", done_n, 1);

        // Single set bit: shows the bit order on the wire
        write_byte(8'h01, 1);
        wait_ack("t6");
        bus.wr_en_i = 1'b0;
        wait_cycles(80);
`ifdef SPI_MASTER_LSB_FIRST_EN
        check_eq("t6_first_mosi", mosi_seq[7], 1'b1);
`else
        check_eq("t6_first_mosi", mosi_seq[7], 1'b0);
`endif
        check_eq("t6_mosi_seq", mosi_seq[7:0], wire_order(8'h01));
        check_eq("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
